// File: rtl/data_mem_ctrl.sv
// Load/store unit: turns one CPU data access into one handshaked bus transaction,
// stalling the core until it completes, with lane steering, extension and fault detection.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wren,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [29:0] lat_word;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic        lat_signed;
  logic        to_flag;

  logic        misaligned;
  logic        cnt_last;
  logic        timeout_hit;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    misaligned = 1'b0;
    req_be     = 4'b1111;
    req_wdata  = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        req_be    = 4'b0001 << cpu_addr[1:0];
        req_wdata = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = cpu_addr[0];
        req_be     = 4'b0011 << cpu_addr[1:0];
        req_wdata  = {2{cpu_wdata[15:0]}};
      end
      default: misaligned = |cpu_addr[1:0];
    endcase
  end

  // The counter covers ISSUE and WAIT together; a grant or read response in the
  // final budgeted cycle still wins over the timeout.
  assign cnt_last    = (cnt >= 16'(TIMEOUT - 1));
  assign timeout_hit = cnt_last && (((state == ISSUE) && !bus_gnt) ||
                                    ((state == WAIT) && !bus_rvalid));

  always_comb begin
    load_byte = bus_rdata[{lat_off, 3'b000} +: 8];
    load_half = bus_rdata[{lat_off[1], 4'b0000} +: 16];
    case (lat_size)
      2'b00:   load_data = {{24{lat_signed & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{lat_signed & load_half[15]}}, load_half};
      default: load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      lat_word   <= '0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_wdata  <= '0;
      lat_size   <= '0;
      lat_off    <= '0;
      lat_signed <= 1'b0;
      to_flag    <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      to_flag <= timeout_hit;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (cpu_req && misaligned) begin
            cpu_rdata <= '0;
          end else if (cpu_req) begin
            lat_word   <= cpu_addr[31:2];
            lat_we     <= cpu_wren;
            lat_be     <= req_be;
            lat_wdata  <= req_wdata;
            lat_size   <= cpu_size;
            lat_off    <= cpu_addr[1:0];
            lat_signed <= cpu_signed;
          end
        end
        ISSUE, WAIT: begin
          cnt <= cnt + 16'd1;
          if ((state == WAIT) && bus_rvalid) cpu_rdata <= load_data;
          else if (timeout_hit)              cpu_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (cpu_req && !misaligned) state_next = ISSUE;
      ISSUE: begin
        if (bus_gnt)       state_next = lat_we ? RESP : WAIT;
        else if (cnt_last) state_next = RESP;
      end
      WAIT:  if (bus_rvalid || cnt_last) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs are gated by reset so the core sees no stall or fault while held.
  always_comb begin
    cpu_stall = 1'b0;
    cpu_fault = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          cpu_stall = cpu_req & ~misaligned;
          cpu_fault = cpu_req & misaligned;
        end
        ISSUE: begin
          cpu_stall = 1'b1;
          bus_req   = 1'b1;
          bus_we    = lat_we;
          bus_addr  = {lat_word, 2'b00};
          bus_wdata = lat_wdata;
          bus_be    = lat_be;
        end
        WAIT:    cpu_stall = 1'b1;
        RESP:    cpu_fault = to_flag;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a driver issues directed and random accesses,
// a slave model answers on the bus, and a monitor checks each completion.
module tb_data_mem_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_wren = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [1:0]  cpu_size = '0;
  logic        cpu_signed = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  data_mem_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_signed(cpu_signed),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_fault(cpu_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fault;
    int          stall;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        zero_next;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model_rdata = '0;

  int          sl_gnt = 0;
  int          sl_rv = 0;
  logic [31:0] sl_rdata = '0;
  logic        exp_bus_ok = 1'b0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_be = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic end_run();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  endtask

  function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input int off);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input int off,
                                             input logic sgn, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * off);
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Bus slave: grants after sl_gnt request cycles, returns data sl_rv cycles into WAIT,
  // and throws a late grant at the DUT when a request was abandoned ungranted.
  int   issue_cnt = 0;
  int   wait_cnt = 0;
  logic granted = 1'b0;
  logic wait_active = 1'b0;
  always @(negedge clk) begin
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = $urandom;
    if (!rst) begin
      issue_cnt   = 0;
      granted     = 1'b0;
      wait_active = 1'b0;
    end else if (bus_req) begin
      check_output("bus_req_allowed", {31'b0, bus_req}, {31'b0, exp_bus_ok});
      if (exp_bus_ok) begin
        check_output("bus_we", {31'b0, bus_we}, {31'b0, exp_we});
        check_output("bus_addr", bus_addr, exp_addr);
        check_output("bus_be", {28'b0, bus_be}, {28'b0, exp_be});
        check_output("bus_wdata", bus_wdata, exp_wdata);
      end
      if (issue_cnt == 0) begin
        granted     = 1'b0;
        wait_active = 1'b0;
      end
      if (issue_cnt == sl_gnt) begin
        bus_gnt = 1'b1;
        granted = 1'b1;
        if (!exp_we) begin
          wait_active = 1'b1;
          wait_cnt    = 0;
        end
      end
      issue_cnt++;
    end else begin
      check_output("bus_idle_fields", bus_addr | bus_wdata | {27'b0, bus_we, bus_be}, 32'h0);
      if (issue_cnt != 0 && !granted) bus_gnt = 1'b1;
      issue_cnt = 0;
      if (wait_active) begin
        if (wait_cnt == sl_rv) begin
          bus_rvalid  = 1'b1;
          bus_rdata   = sl_rdata;
          wait_active = 1'b0;
        end
        wait_cnt++;
      end
    end
  end

  // Monitor: a completion is a fault pulse or the cycle where stall falls.
  logic prev_stall = 1'b0;
  logic pend_zero = 1'b0;
  int   stall_run = 0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      prev_stall = 1'b0;
      pend_zero  = 1'b0;
      stall_run  = 0;
    end else begin
      if (pend_zero) begin
        check_output("rdata_cleared_after_misalign", cpu_rdata, 32'h0);
        pend_zero = 1'b0;
      end
      if (cpu_stall) stall_run++;
      if (cpu_fault || (prev_stall && !cpu_stall)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_completion: got fault=%0b with no access pending", cpu_fault);
        end else begin
          e = sb.pop_front();
          check_output("cpu_fault", {31'b0, cpu_fault}, {31'b0, e.fault});
          check_output("stall_cycles", 32'(stall_run), 32'(e.stall));
          if (e.chk_rdata) check_output("cpu_rdata", cpu_rdata, e.rdata);
          pend_zero = e.zero_next;
        end
        stall_run = 0;
      end
      prev_stall = cpu_stall;
    end
  end

  task automatic apply_stimulus(input logic wren, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic sgn,
                                input int g, input int r, input logic [31:0] rd);
    exp_t e;
    logic mis;
    logic done;
    int   off;
    off = int'(addr % 4);
    mis = is_mis(size, addr);
    e.fault     = 1'b0;
    e.stall     = 0;
    e.rdata     = '0;
    e.chk_rdata = 1'b1;
    e.zero_next = 1'b0;
    if (mis) begin
      e.fault     = 1'b1;
      e.chk_rdata = 1'b0;
      e.zero_next = 1'b1;
      model_rdata = '0;
      exp_bus_ok  = 1'b0;
    end else begin
      exp_bus_ok = 1'b1;
      exp_we     = wren;
      exp_addr   = addr & ~32'h3;
      exp_be     = model_be(size, off);
      exp_wdata  = model_wdata(size, wdata);
      sl_gnt     = g;
      sl_rv      = r;
      sl_rdata   = rd;
      if (g >= T) begin
        e.fault = 1'b1;
        e.stall = 1 + T;
        model_rdata = '0;
      end else if (wren) begin
        e.stall = g + 2;
      end else if (r == 0 || g + 1 + r < T) begin
        e.stall = g + r + 3;
        model_rdata = model_load(size, off, sgn, rd);
      end else begin
        e.fault = 1'b1;
        e.stall = g + 2 + ((T - 1 - g) > 1 ? (T - 1 - g) : 1);
        model_rdata = '0;
      end
      e.rdata = model_rdata;
    end
    if (!mis) e.rdata = model_rdata;
    sb.push_back(e);
    cpu_wren   = wren;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    cpu_size   = size;
    cpu_signed = sgn;
    cpu_req    = 1'b1;
    if (mis) begin
      @(negedge clk);
    end else begin
      done = 1'b0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (!cpu_stall) begin
          done = 1'b1;
          break;
        end
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL stall_release: got stall stuck high expected release within 64 cycles");
        end_run();
      end
    end
    cpu_req = 1'b0;
    if (!mis) @(negedge clk);
  endtask

  task automatic reset_mid_wait();
    exp_bus_ok = 1'b1;
    exp_we     = 1'b0;
    exp_addr   = 32'h40;
    exp_be     = 4'hF;
    exp_wdata  = 32'h0;
    sl_gnt     = 0;
    sl_rv      = 20;
    cpu_wren   = 1'b0;
    cpu_addr   = 32'h40;
    cpu_wdata  = 32'h0;
    cpu_size   = 2'd2;
    cpu_signed = 1'b0;
    cpu_req    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("reset_bus_req", {31'b0, bus_req}, 32'h0);
    check_output("reset_stall", {31'b0, cpu_stall}, 32'h0);
    check_output("reset_fault", {31'b0, cpu_fault}, 32'h0);
    check_output("reset_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_rdata = '0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    end_run();
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    repeat (2) @(negedge clk);
    cpu_req  = 1'b1;
    cpu_size = 2'd2;
    #1;
    check_output("reset_state_rdata", cpu_rdata, 32'h0);
    check_output("reset_state_stall", {31'b0, cpu_stall}, 32'h0);
    check_output("reset_state_fault", {31'b0, cpu_fault}, 32'h0);
    check_output("reset_state_bus", {31'b0, bus_req} | bus_addr | {28'b0, bus_be}, 32'h0);
    @(negedge clk);
    cpu_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    apply_stimulus(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, 0, 32'h0);
    apply_stimulus(1'b0, 32'h0000_2003, 32'h0, 2'd0, 1'b1, 0, 1, 32'h80FF_1234);
    apply_stimulus(1'b0, 32'h0000_2003, 32'h0, 2'd0, 1'b0, 0, 1, 32'h80FF_1234);
    apply_stimulus(1'b1, 32'h0000_0012, 32'h0000_ABCD, 2'd1, 1'b0, 0, 0, 32'h0);
    apply_stimulus(1'b0, 32'h0000_0012, 32'h0, 2'd1, 1'b0, 1, 0, 32'hABCD_0000);
    reset_mid_wait();
    apply_stimulus(1'b0, 32'h0000_0044, 32'h0, 2'd2, 1'b0, 1, 0, 32'h1234_5678);
    apply_stimulus(1'b0, 32'h0000_3002, 32'h0, 2'd2, 1'b0, 0, 0, 32'h0);
    apply_stimulus(1'b1, 32'h0000_0100, 32'h5555_AAAA, 2'd2, 1'b0, 10, 0, 32'h0);
    apply_stimulus(1'b0, 32'h0000_0104, 32'h0, 2'd2, 1'b0, 0, 9, 32'hCAFE_F00D);
    apply_stimulus(1'b0, 32'h0000_0108, 32'h0, 2'd1, 1'b1, 3, 0, 32'h0000_8001);

    for (int n = 0; n < 250; n++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz >= 2'd2) a[1:0] = 2'b00;
      end
      apply_stimulus(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    repeat (6) @(negedge clk);
    check_output("scoreboard_drained", 32'(sb.size()), 32'h0);
    end_run();
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Load/store unit directly downstream of the cpu datapath.
- Takes the ALU-computed address, the store data and the decoder's data-memory write enable, and runs one transaction per request on a handshaked external memory bus.
- Stalls the core until the access completes.
- Handles byte/half/word sizing, little-endian lane steering, load sign/zero extension, misalignment faults and bus timeouts.

Parameters:
- TIMEOUT, 255: cycles spent in ISSUE+WAIT before the access is abandoned with a fault. Must be 1..65535.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  load/store request. Held stable, with all cpu_* inputs, while cpu_stall=1.
- cpu_wren  in  1  1=store, 0=load (decoder data_mem_wren).
- cpu_addr  in  32  byte address (ALU result).
- cpu_wdata  in  32  store data; low byte/half used for narrow stores.
- cpu_size  in  2  00=byte, 01=half, 10/11=word.
- cpu_signed  in  1  1=sign-extend narrow loads, 0=zero-extend.
- cpu_rdata  out  32  load result; valid in the RESP cycle, held until the next completion.
- cpu_stall  out  1  freezes the PC and register-file write.
- cpu_fault  out  1  one-cycle pulse: misaligned access or timeout.
- bus_req  out  1  transaction request.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_gnt  in  1  slave accepts the request this cycle.
- bus_rvalid  in  1  read data valid. Earliest cycle is the one after gnt.
- bus_rdata  in  32  read data.

Behaviour:
- Reset (rst=0, async): state=IDLE; timeout counter=0; all outputs 0, including cpu_rdata. Reset mid-transaction drops bus_req immediately and discards the access. No completion or fault is reported.
- Alignment:
  - half is misaligned when addr[0]=1.
  - word is misaligned when addr[1:0]!=0.
  - byte is never misaligned.
- Byte enables, little-endian:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<addr[1:0].
  - word: 4'b1111.
- Store data replication:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cpu_req=0: stall=0, no action.
  - cpu_req=1 and misaligned: stall=0, cpu_fault=1 combinationally this cycle, cpu_rdata<=0. No bus activity; stay in IDLE.
  - cpu_req=1 and aligned: stall=1 combinationally. Latch addr, we, be, wdata, size, addr[1:0], signed. Clear the counter and go to ISSUE.
- ISSUE:
  - bus_req=1 with the latched fields; stall=1; counter increments.
  - bus_gnt=1 and store: go to RESP.
  - bus_gnt=1 and load: go to WAIT.
  - bus_rvalid is ignored in ISSUE.
- WAIT:
  - bus_req=0; stall=1; counter increments.
  - bus_rvalid=1: cpu_rdata<=extracted data; go to RESP.
- Load extraction:
  - byte: bus_rdata[8*off+:8].
  - half: bus_rdata[16*off[1]+:16].
  - Extension per cpu_signed.
  - word: unchanged.
- Timeout: the counter reaching TIMEOUT in ISSUE or WAIT forces RESP with fault. cpu_rdata<=0 and bus_req drops. A late rvalid/gnt is ignored.
- RESP:
  - stall=0, so the core commits at this edge.
  - cpu_fault=1 only for a timeout.
  - Unconditional return to IDLE. The next request is evaluated there, so back-to-back accesses cost a minimum of 3 cycles each (IDLE→ISSUE→RESP for a store with immediate gnt).
- Simultaneous events:
  - gnt and timeout in the same cycle: gnt wins.
  - rvalid and timeout in the same cycle: rvalid wins, no fault.
- cpu_fault is never asserted together with a valid completion.
- bus_we, bus_addr, bus_be and bus_wdata are 0 whenever bus_req=0.

Test Plan:
- Word store, addr=0x0000_1004, wdata=0xDEADBEEF, gnt in the first ISSUE cycle -> bus_addr=0x1004, be=4'b1111, we=1. Stall high for exactly 2 cycles, then low in RESP; no fault.
- Signed byte load, addr=0x2003, bus_rdata=0x80FF_1234, rvalid 2 cycles after gnt -> be=4'b1000, cpu_rdata=0xFFFF_FF80. Repeat with cpu_signed=0 -> cpu_rdata=0x0000_0080.
- Half store, addr=0x12, wdata=0x0000_ABCD -> bus_addr=0x10, be=4'b1100, bus_wdata=0xABCD_ABCD. Half load from the same address, bus_rdata=0xABCD_0000, unsigned -> cpu_rdata=0x0000_ABCD.
- Misaligned word load, addr=0x3002 -> cpu_fault pulses in the same cycle, stall=0, bus_req never asserted, cpu_rdata=0.
- TIMEOUT=4, gnt held low -> bus_req high 4 cycles, then RESP with cpu_fault=1 and cpu_rdata=0. A gnt arriving after that is ignored.
- rst driven low while in WAIT -> bus_req, stall and cpu_rdata go to 0 immediately. After release, a new word load completes normally.
